// File: rtl/ps2_keyboard.sv
// ps2_keyboard: PS/2 receiver and scan-code set 2 decoder. Holds the Hack key
// code of the most recently pressed mapped key, 0 when none is held.
// Optional build macro: PS2_PARITY_CHECK_EN (enforce odd frame parity).
module ps2_keyboard #(
    parameter int unsigned TIMEOUT_CYCLES = 50000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        ps2Clk,
    input  logic        ps2Data,
    output logic [15:0] key,
    output logic        keyStrobe,
    output logic        frameErr
);

    localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } rx_state_e;

    logic            ps2c_s1_q, ps2c_s2_q, ps2c_d3_q;
    logic            ps2d_s1_q, ps2d_s2_q;
    logic            fall_d;
    rx_state_e       state_q;
    logic [2:0]      bit_cnt_q;
    logic [7:0]      shift_q;
    logic [WD_W-1:0] wd_q;
    logic            ext_q, brk_q;
    logic [7:0]      key_q;
    logic            strobe_q, ferr_q;
    logic            map_valid_d;
    logic [7:0]      map_code_d;
    logic            frame_ok_d;
`ifdef PS2_PARITY_CHECK_EN
    logic            parity_q;
`endif

    // Two-flop synchronisers plus a delayed clock flop for edge detection
    always_ff @(posedge clock) begin
        if (reset) begin
            ps2c_s1_q <= 1'b1;
            ps2c_s2_q <= 1'b1;
            ps2c_d3_q <= 1'b1;
            ps2d_s1_q <= 1'b1;
            ps2d_s2_q <= 1'b1;
        end else begin
            ps2c_s1_q <= ps2Clk;
            ps2c_s2_q <= ps2c_s1_q;
            ps2c_d3_q <= ps2c_s2_q;
            ps2d_s1_q <= ps2Data;
            ps2d_s2_q <= ps2d_s1_q;
        end
    end

    // Falling edge of the synchronised PS/2 clock
    always_comb fall_d = ps2c_d3_q & ~ps2c_s2_q;

    // A frame is accepted when the stop bit currently sampled is 1 (and parity is odd if enforced)
    always_comb begin
`ifdef PS2_PARITY_CHECK_EN
        frame_ok_d = ps2d_s2_q & (^{shift_q, parity_q});
`else
        frame_ok_d = ps2d_s2_q;
`endif
    end

    // Scan-code lookup; the extended table is selected only by a pending 0xE0 prefix
    always_comb begin
        map_valid_d = 1'b1;
        map_code_d  = 8'd0;
        case ({ext_q, shift_q})
            9'h01C: map_code_d = 8'd65;
            9'h032: map_code_d = 8'd66;
            9'h021: map_code_d = 8'd67;
            9'h023: map_code_d = 8'd68;
            9'h024: map_code_d = 8'd69;
            9'h02B: map_code_d = 8'd70;
            9'h034: map_code_d = 8'd71;
            9'h033: map_code_d = 8'd72;
            9'h043: map_code_d = 8'd73;
            9'h03B: map_code_d = 8'd74;
            9'h042: map_code_d = 8'd75;
            9'h04B: map_code_d = 8'd76;
            9'h03A: map_code_d = 8'd77;
            9'h031: map_code_d = 8'd78;
            9'h044: map_code_d = 8'd79;
            9'h04D: map_code_d = 8'd80;
            9'h015: map_code_d = 8'd81;
            9'h02D: map_code_d = 8'd82;
            9'h01B: map_code_d = 8'd83;
            9'h02C: map_code_d = 8'd84;
            9'h03C: map_code_d = 8'd85;
            9'h02A: map_code_d = 8'd86;
            9'h01D: map_code_d = 8'd87;
            9'h022: map_code_d = 8'd88;
            9'h035: map_code_d = 8'd89;
            9'h01A: map_code_d = 8'd90;
            9'h045: map_code_d = 8'd48;
            9'h016: map_code_d = 8'd49;
            9'h01E: map_code_d = 8'd50;
            9'h026: map_code_d = 8'd51;
            9'h025: map_code_d = 8'd52;
            9'h02E: map_code_d = 8'd53;
            9'h036: map_code_d = 8'd54;
            9'h03D: map_code_d = 8'd55;
            9'h03E: map_code_d = 8'd56;
            9'h046: map_code_d = 8'd57;
            9'h029: map_code_d = 8'd32;
            9'h05A: map_code_d = 8'd128;
            9'h066: map_code_d = 8'd129;
            9'h076: map_code_d = 8'd140;
            9'h16B: map_code_d = 8'd130;
            9'h175: map_code_d = 8'd131;
            9'h174: map_code_d = 8'd132;
            9'h172: map_code_d = 8'd133;
            9'h16C: map_code_d = 8'd134;
            9'h169: map_code_d = 8'd135;
            9'h171: map_code_d = 8'd139;
            default: map_valid_d = 1'b0;
        endcase
    end

    // Receiver FSM, watchdog, prefix decoder and registered outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            wd_q      <= '0;
            ext_q     <= 1'b0;
            brk_q     <= 1'b0;
            key_q     <= '0;
            strobe_q  <= 1'b0;
            ferr_q    <= 1'b0;
`ifdef PS2_PARITY_CHECK_EN
            parity_q  <= 1'b0;
`endif
        end else begin
            strobe_q <= 1'b0;
            ferr_q   <= 1'b0;
            if (state_q == IDLE) begin
                wd_q <= '0;
                if (fall_d && !ps2d_s2_q) begin
                    state_q   <= DATA;
                    bit_cnt_q <= '0;
                end
            end else if (fall_d) begin
                wd_q <= '0;
                case (state_q)
                    DATA: begin
                        shift_q   <= {ps2d_s2_q, shift_q[7:1]};
                        bit_cnt_q <= bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) state_q <= PARITY;
                    end
                    PARITY: begin
`ifdef PS2_PARITY_CHECK_EN
                        parity_q <= ps2d_s2_q;
`endif
                        state_q  <= STOP;
                    end
                    default: begin
                        state_q <= IDLE;
                        if (!frame_ok_d) begin
                            ferr_q <= 1'b1;
                        end else if (shift_q == 8'hE0) begin
                            ext_q <= 1'b1;
                        end else if (shift_q == 8'hF0) begin
                            brk_q <= 1'b1;
                        end else begin
                            ext_q <= 1'b0;
                            brk_q <= 1'b0;
                            if (map_valid_d) begin
                                if (brk_q) begin
                                    if (key_q == map_code_d) begin
                                        key_q    <= '0;
                                        strobe_q <= 1'b1;
                                    end
                                end else if (key_q != map_code_d) begin
                                    key_q    <= map_code_d;
                                    strobe_q <= 1'b1;
                                end
                            end
                        end
                    end
                endcase
            end else if (wd_q == WD_LAST) begin
                state_q <= IDLE;
                wd_q    <= '0;
                ferr_q  <= 1'b1;
            end else begin
                wd_q <= wd_q + WD_W'(1);
            end
        end
    end

    assign key       = {8'h00, key_q};
    assign keyStrobe = strobe_q;
    assign frameErr  = ferr_q;

endmodule

// File: tb/tb_ps2_keyboard.sv
// Directed testbench for ps2_keyboard: drives PS/2 frames bit by bit and
// checks key, keyStrobe pulse counts and frameErr pulse counts.
module tb_ps2_keyboard;

    localparam int unsigned TO = 300;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        ps2Clk = 1'b1;
    logic        ps2Data = 1'b1;
    logic [15:0] key;
    logic        keyStrobe;
    logic        frameErr;

    int passed = 0;
    int failed = 0;
    int total  = 0;
    int sc = 0;
    int ec = 0;
    int s0, e0;

    ps2_keyboard #(.TIMEOUT_CYCLES(TO)) dut (
        .clock(clock),
        .reset(reset),
        .ps2Clk(ps2Clk),
        .ps2Data(ps2Data),
        .key(key),
        .keyStrobe(keyStrobe),
        .frameErr(frameErr)
    );

    always #5 clock = ~clock;

    // Count high cycles of each pulse output, sampled away from the active edge
    always @(negedge clock) begin
        if (keyStrobe === 1'b1) sc++;
        if (frameErr === 1'b1) ec++;
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic ps2_bit(input logic b);
        ps2Data = b;
        cyc(4);
        ps2Clk = 1'b0;
        cyc(8);
        ps2Clk = 1'b1;
        cyc(4);
    endtask

    task automatic frame_raw(input logic [7:0] d, input logic par, input logic stp);
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(d[i]);
        ps2_bit(par);
        ps2_bit(stp);
        ps2Data = 1'b1;
    endtask

    task automatic frame(input logic [7:0] d);
        frame_raw(d, ~^d, 1'b1);
    endtask

    task automatic mark();
        s0 = sc;
        e0 = ec;
    endtask

    task automatic check(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic settle_check(input string tag, input int k, input int ns, input int ne);
        cyc(10);
        check({tag, "_key"}, int'(key), k);
        check({tag, "_strobes"}, sc - s0, ns);
        check({tag, "_errs"}, ec - e0, ne);
    endtask

    initial begin
        // Reset with idle lines
        cyc(2);
        reset = 1'b0;
        #1;
        check("reset_key", int'(key), 0);
        mark();
        cyc(1000);
        check("idle_strobes", sc - s0, 0);
        check("idle_errs", ec - e0, 0);

        // Make / break A
        mark(); frame(8'h1C);
        settle_check("make_A", 65, 1, 0);
        mark(); frame(8'hF0); frame(8'h1C);
        settle_check("break_A", 0, 1, 0);

        // Extended up arrow make / break
        mark(); frame(8'hE0); frame(8'h75);
        settle_check("make_up", 131, 1, 0);
        mark(); frame(8'hE0); frame(8'hF0); frame(8'h75);
        settle_check("break_up", 0, 1, 0);

        // Extended code without prefix is unmapped
        mark(); frame(8'h1C);
        settle_check("make_A2", 65, 1, 0);
        mark(); frame(8'h75);
        settle_check("plain_75", 65, 0, 0);
        // Letter code behind an 0xE0 prefix is unmapped, and clears the prefix
        mark(); frame(8'hE0); frame(8'h32);
        settle_check("ext_32", 65, 0, 0);
        mark(); frame(8'h32);
        settle_check("make_B0", 66, 1, 0);
        mark(); frame(8'hF0); frame(8'h32);
        settle_check("break_B0", 0, 1, 0);

        // Rollover
        mark(); frame(8'h1C); frame(8'h32);
        settle_check("roll_AB", 66, 2, 0);
        mark(); frame(8'hF0); frame(8'h1C);
        settle_check("roll_brkA", 66, 0, 0);
        mark(); frame(8'hF0); frame(8'h32);
        settle_check("roll_brkB", 0, 1, 0);

        // Bad stop bit
        mark(); frame(8'h1C);
        settle_check("make_A3", 65, 1, 0);
        mark(); frame_raw(8'h29, ~^8'h29, 1'b0);
        settle_check("stop_err", 65, 0, 1);

        // Stall after start + 4 data bits
        mark();
        ps2_bit(1'b0);
        ps2_bit(1'b1); ps2_bit(1'b0); ps2_bit(1'b0); ps2_bit(1'b1);
        ps2Data = 1'b1;
        cyc(TO + 50);
        settle_check("timeout", 65, 0, 1);
        mark(); frame(8'h29);
        settle_check("space", 32, 1, 0);
        mark(); frame(8'h29);
        settle_check("space_rpt", 32, 0, 0);

        // 0x5A with even parity (parity bit 0)
        mark(); frame_raw(8'h5A, 1'b0, 1'b1);
`ifdef PS2_PARITY_CHECK_EN
        settle_check("parity", 32, 0, 1);
`else
        settle_check("parity", 128, 1, 0);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
